load_queue_ordered: RTL and testbench

Parametrised, age-ordered load queue between dispatch and the LSU memory pipeline. Entries are allocated in program order into a circular buffer and receive addresses from NUM_EXEC execution ports. The queue issues the oldest ready load under a valid/ready handshake and keeps each entry until the LSU reports completion. The LSU can send a load back for replay, and completed loads retire in order from the head. An optional ordered mode holds a load until every older store has drained from the store data queue.

---
 rtl/load_queue_ordered_if.sv | 58 +++++
 rtl/load_queue_ordered.sv | 161 ++++++++++++++++
 tb/tb_load_queue_ordered.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_queue_ordered_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_queue_ordered_if
//  Description : Bundle of the dispatch, execute, issue, LSU-feedback and
//                retire signals of the load queue.
//                master = the environment driving the queue,
//                slave  = the load queue itself.
//                issue_entry packs {valid, addr_valid, issued, done,
//                sdq_marker, addr}, MSB first.
//  Revision    : 1.0  initial release
// ============================================================================
interface load_queue_ordered_if #(
    parameter int ENTRIES    = 8,
    parameter int ADDR_W     = 32,
    parameter int SDQ_MARK_W = 4,
    parameter int NUM_EXEC   = 2
);
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int ENTRY_W = 4 + SDQ_MARK_W + ADDR_W;

    logic                         flush;
    logic                         disp_vld;
    logic [SDQ_MARK_W-1:0]        disp_sdq_marker;
    logic [IDX_W-1:0]             disp_ldq_idx;
    logic                         disp_full;
    logic [NUM_EXEC-1:0]          exec_vld;
    logic [NUM_EXEC*IDX_W-1:0]    exec_ldq_idx;
    logic [NUM_EXEC*ADDR_W-1:0]   exec_addr;
    logic [SDQ_MARK_W-1:0]        sdq_head_marker;
    logic                         issue_vld;
    logic                         issue_rdy;
    logic [IDX_W-1:0]             issue_idx;
    logic [ENTRY_W-1:0]           issue_entry;
    logic                         lsu_done_vld;
    logic [IDX_W-1:0]             lsu_done_idx;
    logic                         lsu_replay_vld;
    logic [IDX_W-1:0]             lsu_replay_idx;
    logic                         retire_vld;
    logic [IDX_W-1:0]             retire_idx;
    logic [IDX_W:0]               count;

    modport master (
        output flush, disp_vld, disp_sdq_marker, exec_vld, exec_ldq_idx,
               exec_addr, sdq_head_marker, issue_rdy, lsu_done_vld,
               lsu_done_idx, lsu_replay_vld, lsu_replay_idx,
        input  disp_ldq_idx, disp_full, issue_vld, issue_idx, issue_entry,
               retire_vld, retire_idx, count
    );

    modport slave (
        input  flush, disp_vld, disp_sdq_marker, exec_vld, exec_ldq_idx,
               exec_addr, sdq_head_marker, issue_rdy, lsu_done_vld,
               lsu_done_idx, lsu_replay_vld, lsu_replay_idx,
        output disp_ldq_idx, disp_full, issue_vld, issue_idx, issue_entry,
               retire_vld, retire_idx, count
    );
endinterface
`default_nettype wire

// File: rtl/load_queue_ordered.sv
`default_nettype none
// ============================================================================
//  Module      : load_queue_ordered
//  Description : Age-ordered circular load queue. Loads are allocated in
//                program order, receive addresses from NUM_EXEC execute
//                ports, issue oldest-ready-first to the LSU, are held until
//                the LSU reports done (or replayed), and retire in order.
//                With ORDERED=1 a load waits until its store-queue marker
//                matches the store-queue head marker.
//  Ports       : clk, rst (sync, active-high), lq (slave modport carrying
//                dispatch / execute / issue / LSU feedback / retire / count)
//  Revision    : 1.0  initial release
// ============================================================================
module load_queue_ordered #(
    parameter int ENTRIES    = 8,
    parameter int ADDR_W     = 32,
    parameter int SDQ_MARK_W = 4,
    parameter int NUM_EXEC   = 2,
    parameter int ORDERED    = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    load_queue_ordered_if.slave lq
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic                  valid;
        logic                  addr_valid;
        logic                  issued;
        logic                  done;
        logic [SDQ_MARK_W-1:0] sdq_marker;
        logic [ADDR_W-1:0]     addr;
    } entry_t;

    entry_t                entries [ENTRIES];
    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;
    logic [IDX_W:0]        entry_count;
    // Registered copy of the store-queue head marker keeps issue_* free of
    // any input-to-output path.
    logic [SDQ_MARK_W-1:0] sdq_head_q;

    logic [ENTRIES-1:0]    ready;
    logic                  found;
    logic [IDX_W-1:0]      sel;
    logic [IDX_W-1:0]      cand;
    logic                  full;
    logic                  alloc_fire;
    logic                  retire_fire;
    logic                  issue_fire;
    entry_t                new_entry;

    // ------------------------------------------------------------------
    // Readiness per entry
    // ------------------------------------------------------------------
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ready
        assign ready[i] = entries[i].valid & entries[i].addr_valid &
                          ~entries[i].issued & ~entries[i].done &
                          ((ORDERED == 0) || (entries[i].sdq_marker == sdq_head_q));
    end

    // ------------------------------------------------------------------
    // Oldest-first selection: scan age offsets from youngest to oldest so
    // the last hit (smallest offset from head) is the one kept.
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            cand = head + IDX_W'(k);
            if (ready[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign full        = (entry_count == (IDX_W+1)'(ENTRIES));
    assign alloc_fire  = lq.disp_vld & ~full;
    assign retire_fire = entries[head].valid & entries[head].done;
    assign issue_fire  = found & lq.issue_rdy;

    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.sdq_marker = lq.disp_sdq_marker;
    end

    // ------------------------------------------------------------------
    // Outputs (registered state only)
    // ------------------------------------------------------------------
    assign lq.disp_ldq_idx = tail;
    assign lq.disp_full    = full;
    assign lq.issue_vld    = found;
    assign lq.issue_idx    = sel;
    assign lq.issue_entry  = found ? entries[sel] : '0;
    assign lq.retire_vld   = retire_fire;
    assign lq.retire_idx   = head;
    assign lq.count        = entry_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sdq_head_q <= '0;
        end else begin
            sdq_head_q <= lq.sdq_head_marker;
        end
    end

    // ------------------------------------------------------------------
    // Entry array and pointers. Later non-blocking writes to the same
    // field override earlier ones, which encodes the priorities:
    // higher exec port over lower, done over replay.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || lq.flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
            head        <= '0;
            tail        <= '0;
            entry_count <= '0;
        end else begin
            for (int p = 0; p < NUM_EXEC; p++) begin
                if (lq.exec_vld[p] && entries[lq.exec_ldq_idx[p*IDX_W +: IDX_W]].valid) begin
                    entries[lq.exec_ldq_idx[p*IDX_W +: IDX_W]].addr       <= lq.exec_addr[p*ADDR_W +: ADDR_W];
                    entries[lq.exec_ldq_idx[p*IDX_W +: IDX_W]].addr_valid <= 1'b1;
                end
            end

            if (issue_fire) begin
                entries[sel].issued <= 1'b1;
            end
            if (lq.lsu_replay_vld && entries[lq.lsu_replay_idx].valid) begin
                entries[lq.lsu_replay_idx].issued <= 1'b0;
            end
            if (lq.lsu_done_vld && entries[lq.lsu_done_idx].valid) begin
                entries[lq.lsu_done_idx].done <= 1'b1;
            end

            // Head and tail never coincide while both fire: a retire needs a
            // valid head (count>0) and an allocation needs count<ENTRIES.
            if (retire_fire) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (alloc_fire) begin
                entries[tail] <= new_entry;
                tail          <= tail + 1'b1;
            end

            case ({alloc_fire, retire_fire})
                2'b10:   entry_count <= entry_count + 1'b1;
                2'b01:   entry_count <= entry_count - 1'b1;
                default: entry_count <= entry_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_load_queue_ordered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_queue_ordered
//  Description : Directed bench for load_queue_ordered: one unordered and one
//                ordered instance, a vector table for fill/overflow and
//                hand-written sequences for wrap, backpressure, replay,
//                exec conflicts, flush and ordered issue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_queue_ordered;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    load_queue_ordered_if #(.ENTRIES(8), .ADDR_W(32), .SDQ_MARK_W(4), .NUM_EXEC(2)) bus0 ();
    load_queue_ordered_if #(.ENTRIES(8), .ADDR_W(32), .SDQ_MARK_W(4), .NUM_EXEC(2)) bus1 ();

    load_queue_ordered #(.ENTRIES(8), .ADDR_W(32), .SDQ_MARK_W(4), .NUM_EXEC(2), .ORDERED(0))
        dut0 (.clk(clk), .rst(rst), .lq(bus0));
    load_queue_ordered #(.ENTRIES(8), .ADDR_W(32), .SDQ_MARK_W(4), .NUM_EXEC(2), .ORDERED(1))
        dut1 (.clk(clk), .rst(rst), .lq(bus1));

    typedef struct {
        logic       disp_vld;
        logic [2:0] exp_idx;
        logic       exp_full;
        logic [3:0] exp_count;
    } fill_vec_t;

    fill_vec_t fill_tab [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.flush = 0; bus0.disp_vld = 0; bus0.disp_sdq_marker = 0;
        bus0.exec_vld = 0; bus0.exec_ldq_idx = 0; bus0.exec_addr = 0;
        bus0.sdq_head_marker = 0; bus0.issue_rdy = 0;
        bus0.lsu_done_vld = 0; bus0.lsu_done_idx = 0;
        bus0.lsu_replay_vld = 0; bus0.lsu_replay_idx = 0;
        bus1.flush = 0; bus1.disp_vld = 0; bus1.disp_sdq_marker = 0;
        bus1.exec_vld = 0; bus1.exec_ldq_idx = 0; bus1.exec_addr = 0;
        bus1.sdq_head_marker = 4'h2; bus1.issue_rdy = 0;
        bus1.lsu_done_vld = 0; bus1.lsu_done_idx = 0;
        bus1.lsu_replay_vld = 0; bus1.lsu_replay_idx = 0;

        //                 disp  idx   full  count
        fill_tab[0] = '{1'b1, 3'd0, 1'b0, 4'd0};
        fill_tab[1] = '{1'b1, 3'd1, 1'b0, 4'd1};
        fill_tab[2] = '{1'b1, 3'd2, 1'b0, 4'd2};
        fill_tab[3] = '{1'b1, 3'd3, 1'b0, 4'd3};
        fill_tab[4] = '{1'b1, 3'd4, 1'b0, 4'd4};
        fill_tab[5] = '{1'b1, 3'd5, 1'b0, 4'd5};
        fill_tab[6] = '{1'b1, 3'd6, 1'b0, 4'd6};
        fill_tab[7] = '{1'b1, 3'd7, 1'b0, 4'd7};
        fill_tab[8] = '{1'b1, 3'd0, 1'b1, 4'd8};

        tick(); tick();
        rst = 0;

        // Reset state
        chk("rst_count",       64'(bus0.count), 64'd0);
        chk("rst_full",        64'(bus0.disp_full), 64'd0);
        chk("rst_disp_idx",    64'(bus0.disp_ldq_idx), 64'd0);
        chk("rst_issue_vld",   64'(bus0.issue_vld), 64'd0);
        chk("rst_issue_idx",   64'(bus0.issue_idx), 64'd0);
        chk("rst_issue_entry", 64'(bus0.issue_entry), 64'd0);
        chk("rst_retire_vld",  64'(bus0.retire_vld), 64'd0);
        chk("rst_retire_idx",  64'(bus0.retire_idx), 64'd0);

        // Fill and overflow
        for (int i = 0; i < 9; i++) begin
            bus0.disp_vld = fill_tab[i].disp_vld;
            chk("fill_idx",   64'(bus0.disp_ldq_idx), 64'(fill_tab[i].exp_idx));
            chk("fill_full",  64'(bus0.disp_full),    64'(fill_tab[i].exp_full));
            chk("fill_count", 64'(bus0.count),        64'(fill_tab[i].exp_count));
            tick();
        end
        bus0.disp_vld = 0;
        chk("ovf_count", 64'(bus0.count), 64'd8);
        chk("ovf_full",  64'(bus0.disp_full), 64'd1);
        chk("ovf_tail",  64'(bus0.disp_ldq_idx), 64'd0);

        // Retire 0..5 via done (done at edge N -> retire_vld in N+1)
        for (int i = 0; i < 6; i++) begin
            bus0.lsu_done_vld = 1; bus0.lsu_done_idx = 3'(i);
            tick();
            chk("ret_vld", 64'(bus0.retire_vld), 64'd1);
            chk("ret_idx", 64'(bus0.retire_idx), 64'(i));
        end
        bus0.lsu_done_vld = 0;
        tick();
        chk("ret_idle",  64'(bus0.retire_vld), 64'd0);
        chk("ret_count", 64'(bus0.count), 64'd2);

        // Allocate younger loads into 0..2 after wrap
        for (int i = 0; i < 3; i++) begin
            bus0.disp_vld = 1;
            chk("wrap_alloc_idx", 64'(bus0.disp_ldq_idx), 64'(i));
            tick();
        end
        bus0.disp_vld = 0;
        chk("wrap_count", 64'(bus0.count), 64'd5);

        // Oldest-first: addresses to 1 and 6 together; 6 is older
        bus0.exec_vld = 2'b11; bus0.exec_ldq_idx = {3'd6, 3'd1};
        bus0.exec_addr = {32'h666, 32'h111};
        tick();
        bus0.exec_vld = 0;
        chk("oldest_vld",   64'(bus0.issue_vld), 64'd1);
        chk("oldest_idx",   64'(bus0.issue_idx), 64'd6);
        chk("oldest_entry", 64'(bus0.issue_entry), {24'd0, 4'b1100, 4'h0, 32'h666});
        bus0.issue_rdy = 1;
        tick();
        chk("second_idx", 64'(bus0.issue_idx), 64'd1);
        chk("second_vld", 64'(bus0.issue_vld), 64'd1);
        tick();
        bus0.issue_rdy = 0;
        chk("drained_vld", 64'(bus0.issue_vld), 64'd0);

        // Backpressure: entry 7 held three cycles
        bus0.exec_vld = 2'b01; bus0.exec_ldq_idx = {3'd0, 3'd7};
        bus0.exec_addr = {32'h0, 32'h777};
        tick();
        bus0.exec_vld = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_vld", 64'(bus0.issue_vld), 64'd1);
            chk("bp_idx", 64'(bus0.issue_idx), 64'd7);
            tick();
        end
        bus0.issue_rdy = 1;
        tick();
        bus0.issue_rdy = 0;
        chk("bp_accepted", 64'(bus0.issue_vld), 64'd0);

        // Replay 7, it becomes ready again
        bus0.lsu_replay_vld = 1; bus0.lsu_replay_idx = 3'd7;
        tick();
        bus0.lsu_replay_vld = 0;
        chk("replay_vld", 64'(bus0.issue_vld), 64'd1);
        chk("replay_idx", 64'(bus0.issue_idx), 64'd7);
        bus0.issue_rdy = 1;
        tick();
        bus0.issue_rdy = 0;
        chk("reissued", 64'(bus0.issue_vld), 64'd0);

        // Done 6 then 7; retire in order
        bus0.lsu_done_vld = 1; bus0.lsu_done_idx = 3'd6;
        tick();
        chk("ret6_vld", 64'(bus0.retire_vld), 64'd1);
        chk("ret6_idx", 64'(bus0.retire_idx), 64'd6);
        bus0.lsu_done_idx = 3'd7;
        tick();
        bus0.lsu_done_vld = 0;
        chk("ret7_vld", 64'(bus0.retire_vld), 64'd1);
        chk("ret7_idx", 64'(bus0.retire_idx), 64'd7);
        tick();
        chk("ret_after", 64'(bus0.retire_vld), 64'd0);
        chk("cnt_after", 64'(bus0.count), 64'd3);

        // Exec conflict on index 4
        for (int i = 3; i < 5; i++) begin
            bus0.disp_vld = 1;
            chk("conf_alloc_idx", 64'(bus0.disp_ldq_idx), 64'(i));
            tick();
        end
        bus0.disp_vld = 0;
        bus0.exec_vld = 2'b11; bus0.exec_ldq_idx = {3'd4, 3'd4};
        bus0.exec_addr = {32'h200, 32'h100};
        tick();
        bus0.exec_vld = 0;
        chk("conf_idx",   64'(bus0.issue_idx), 64'd4);
        chk("conf_entry", 64'(bus0.issue_entry), {24'd0, 4'b1100, 4'h0, 32'h200});

        // Done and replay together: done wins, entry no longer ready
        bus0.lsu_done_vld = 1; bus0.lsu_done_idx = 3'd4;
        bus0.lsu_replay_vld = 1; bus0.lsu_replay_idx = 3'd4;
        tick();
        bus0.lsu_done_vld = 0; bus0.lsu_replay_vld = 0;
        chk("done_wins", 64'(bus0.issue_vld), 64'd0);
        chk("conf_count", 64'(bus0.count), 64'd5);

        // Flush with 5 entries and a pending issue
        bus0.exec_vld = 2'b01; bus0.exec_ldq_idx = {3'd0, 3'd2};
        bus0.exec_addr = {32'h0, 32'h222};
        tick();
        bus0.exec_vld = 0;
        chk("pend_vld", 64'(bus0.issue_vld), 64'd1);
        chk("pend_idx", 64'(bus0.issue_idx), 64'd2);
        bus0.flush = 1; bus0.disp_vld = 1; bus0.issue_rdy = 1;
        tick();
        bus0.flush = 0; bus0.disp_vld = 0; bus0.issue_rdy = 0;
        chk("flush_count",  64'(bus0.count), 64'd0);
        chk("flush_vld",    64'(bus0.issue_vld), 64'd0);
        chk("flush_idx",    64'(bus0.disp_ldq_idx), 64'd0);
        chk("flush_full",   64'(bus0.disp_full), 64'd0);
        chk("flush_retire", 64'(bus0.retire_vld), 64'd0);
        bus0.disp_vld = 1;
        chk("post_flush_idx", 64'(bus0.disp_ldq_idx), 64'd0);
        tick();
        bus0.disp_vld = 0;
        chk("post_flush_count", 64'(bus0.count), 64'd1);

        // Ordered mode: marker 3 waits for head marker 3
        bus1.disp_sdq_marker = 4'h3; bus1.disp_vld = 1;
        tick();
        bus1.disp_vld = 0;
        bus1.exec_vld = 2'b01; bus1.exec_ldq_idx = {3'd0, 3'd0};
        bus1.exec_addr = {32'h0, 32'h40};
        tick();
        bus1.exec_vld = 0;
        for (int i = 0; i < 3; i++) begin
            chk("ord_hold", 64'(bus1.issue_vld), 64'd0);
            tick();
        end
        bus1.sdq_head_marker = 4'h3;
        #1;
        chk("ord_same_cycle", 64'(bus1.issue_vld), 64'd0);
        tick();
        chk("ord_vld",   64'(bus1.issue_vld), 64'd1);
        chk("ord_idx",   64'(bus1.issue_idx), 64'd0);
        chk("ord_entry", 64'(bus1.issue_entry), {24'd0, 4'b1100, 4'h3, 32'h40});
        chk("ord_count", 64'(bus1.count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
